// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state and mode encodings for serial_sub_unit
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic SUB_AB = 1'b0;
  localparam logic SUB_BA = 1'b1;
endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: 1-bit full subtractor, d = x - y - bi with borrow-out bo
// ports: x minuend bit, y subtrahend bit, bi borrow-in, d difference bit, bo borrow-out
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_sub_unit.sv
// serial_sub_unit: multi-cycle subtractor, SLICE bits per clock, LSB slice first
// ports: clk, rst_n (async active-low); start/mode/A/B/Bin request, sampled when idle;
//        busy while running; done one-cycle pulse; Diff/Borr/zero held until next start
module serial_sub_unit
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr,
  output logic             zero
);
  localparam int STEPS = WIDTH / SLICE;
  localparam int CW = $clog2(STEPS + 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, res, res_nxt;
  logic [CW-1:0] cnt;
  logic br, last;
  logic [SLICE:0] bc;
  logic [SLICE-1:0] d;
  assign bc[0] = br;
  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    full_sub_cell u_cell (.x(a_r[i]), .y(b_r[i]), .bi(bc[i]), .d(d[i]), .bo(bc[i+1]));
  end
  // new slice enters at the top; after STEPS shifts the LSB slice sits at bit 0
  assign res_nxt = (res >> SLICE) | (WIDTH'(d) << (WIDTH - SLICE));
  assign last = cnt == CW'(STEPS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      res  <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      Diff <= '0;
      Borr <= 1'b0;
      zero <= 1'b0;
    end else if (state != RUN && start) begin
      a_r <= mode == SUB_BA ? B : A;
      b_r <= mode == SUB_BA ? A : B;
      br  <= Bin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_r <= a_r >> SLICE;
      b_r <= b_r >> SLICE;
      br  <= bc[SLICE];
      res <= res_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        Diff <= res_nxt;
        Borr <= bc[SLICE];
        zero <= res_nxt == '0;
      end
    end
endmodule

// File: tb/tb_serial_sub_unit.sv
// tb_serial_sub_unit: directed table-driven checks of serial_sub_unit (SLICE 1 and 4) and full_sub_cell
module tb_serial_sub_unit;
  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       z;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start1 = 1'b0, start4 = 1'b0, mode = 1'b0, Bin = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic busy1, done1, borr1, zero1, busy4, done4, borr4, zero4;
  logic [7:0] d1, d4;
  logic cx = 1'b0, cy = 1'b0, cbi = 1'b0, cd, cbo;
  logic [7:0] pd1 = '0, pd4 = '0;
  logic pb1 = 1'b0, pz1 = 1'b0, pb4 = 1'b0, pz4 = 1'b0;
  int total = 0, passed = 0;
  vec_t tv[9];
  always #5 clk = ~clk;
  serial_sub_unit #(.WIDTH(8), .SLICE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .A(A), .B(B), .Bin(Bin),
    .busy(busy1), .done(done1), .Diff(d1), .Borr(borr1), .zero(zero1)
  );
  serial_sub_unit #(.WIDTH(8), .SLICE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .A(A), .B(B), .Bin(Bin),
    .busy(busy4), .done(done4), .Diff(d4), .Borr(borr4), .zero(zero4)
  );
  full_sub_cell uc (.x(cx), .y(cy), .bi(cbi), .d(cd), .bo(cbo));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Starts an operation in the current or next cycle and checks both units edge by edge.
  // k counts edges after the start edge; u1 is done at k=8, u4 at k=2. Returns in u1's DONE cycle.
  task automatic op(input vec_t v, input logic g1, input logic g4, input logic inj);
    @(negedge clk);
    mode = v.m; A = v.a; B = v.b; Bin = v.bi; start1 = g1; start4 = g4;
    @(posedge clk);
    #1;
    start1 = 1'b0; start4 = 1'b0;
    A = 8'($urandom); B = 8'($urandom); mode = ~mode; Bin = ~Bin;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (g1) begin
        chk("busy1", busy1, k < 8);
        chk("done1", done1, k == 8);
        chk("diff1", d1, k < 8 ? pd1 : v.d);
        chk("borr1", borr1, k < 8 ? pb1 : v.bo);
        chk("zero1", zero1, k < 8 ? pz1 : v.z);
      end
      if (g4 && k <= 3) begin
        chk("busy4", busy4, k < 2);
        chk("done4", done4, k == 2);
        chk("diff4", d4, k < 2 ? pd4 : v.d);
        chk("borr4", borr4, k < 2 ? pb4 : v.bo);
        chk("zero4", zero4, k < 2 ? pz4 : v.z);
      end
      if (inj && k == 3) begin
        start1 = 1'b1; A = 8'h00; B = 8'h01; mode = 1'b1; Bin = 1'b1;
      end
      if (inj && k == 4) start1 = 1'b0;
    end
    if (g1) begin
      pd1 = v.d; pb1 = v.bo; pz1 = v.z;
    end
    if (g4) begin
      pd4 = v.d; pb4 = v.bo; pz4 = v.z;
    end
  endtask
  initial begin
    logic [7:0] dtab, btab;
    logic saw;
    dtab = 8'b1001_0110;
    btab = 8'b1000_1110;
    tv[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    tv[1] = '{1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tv[2] = '{1'b0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1};
    tv[3] = '{1'b1, 8'h3C, 8'h5A, 1'b0, 8'h1E, 1'b0, 1'b0};
    tv[4] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};
    tv[5] = '{1'b1, 8'h01, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0};
    tv[6] = '{1'b0, 8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0};
    tv[7] = '{1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1};
    tv[8] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      {cx, cy, cbi} = 3'(i);
      #1;
      chk($sformatf("cell_d[%0d]", i), cd, dtab[i]);
      chk($sformatf("cell_bo[%0d]", i), cbo, btab[i]);
    end
    #3;
    chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0); chk("rst_diff1", d1, 0);
    chk("rst_borr1", borr1, 0); chk("rst_zero1", zero1, 0);
    chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0); chk("rst_diff4", d4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      op(tv[i], 1'b1, 1'b1, 1'b0);
      if (i % 2 == 0) repeat (2) @(posedge clk);
    end
    op(tv[0], 1'b1, 1'b0, 1'b1);
    op(tv[1], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    mode = 1'b0; A = 8'h5A; B = 8'h3C; Bin = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy1", busy1, 0); chk("arst_done1", done1, 0); chk("arst_diff1", d1, 0);
    chk("arst_borr1", borr1, 0); chk("arst_zero1", zero1, 0);
    chk("arst_diff4", d4, 0);
    pd1 = '0; pb1 = 1'b0; pz1 = 1'b0; pd4 = '0; pb4 = 1'b0; pz4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      saw = saw | done1 | busy1;
    end
    chk("no_done_after_reset", saw, 0);
    op(tv[4], 1'b1, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_sub_unit.md
SERIAL_SUB_UNIT -- requirements
Module: serial_sub_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, at least 1.
REQ-002 Parameter SLICE, default 1: bits processed per clock; SLICE SHALL divide WIDTH exactly; STEPS = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 mode  input  1  0: compute A-B; 1: compute B-A (reverse subtract); sampled with start.
REQ-007 A  input  WIDTH  minuend operand for mode 0; sampled with start.
REQ-008 B  input  WIDTH  subtrahend operand for mode 0; sampled with start.
REQ-009 Bin  input  1  initial borrow-in at the LSB; sampled with start.
REQ-010 busy  output  1  high while a subtraction is in progress.
REQ-011 done  output  1  one-cycle pulse marking a valid result.
REQ-012 Diff  output  WIDTH  difference; held from done until the next accepted start.
REQ-013 Borr  output  1  final borrow-out of the MSB slice; held with Diff.
REQ-014 zero  output  1  high when Diff is all zeros; held with Diff.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at an edge SHALL latch the operands, mode and Bin, clear the step counter, and enter RUN.
REQ-017 mode=1 SHALL swap the latched operands, so Diff = B - A - Bin.
REQ-018 Each RUN edge SHALL process one SLICE-bit group, LSB group first, through a ripple of 1-bit full-subtractor cells.
REQ-019 Each cell: d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
REQ-020 The slice borrow-out SHALL register as the borrow-in for the next slice.
REQ-021 After the STEPS-th RUN edge, the FSM SHALL enter DONE.
REQ-022 In DONE, done=1 and busy=0; Diff, Borr and zero SHALL be updated at that same edge.
REQ-023 Latency: with start accepted at edge E0, done SHALL be high exactly in the cycle after edge E0+STEPS.
REQ-024 busy SHALL be high in the cycles after edges E0 through E0+STEPS-1.
REQ-025 DONE SHALL last one cycle: it goes to IDLE, or to RUN if start=1 at that edge.
REQ-026 start while busy=1 SHALL be ignored; operands and progress SHALL be unaffected.
REQ-027 Operand changes while busy=1 SHALL have no effect on the result.
REQ-028 Diff and Borr SHALL equal the WIDTH-bit modulo result and borrow of the full-width subtraction for every input combination.
REQ-029 Borr=1 SHALL mean that the unsigned result underflowed.
REQ-030 Diff, Borr and zero SHALL stay at their previous values during RUN; no partial results SHALL be visible.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, Diff=0, Borr=0, zero=0, and clear the counter and internal registers.
REQ-032 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-033 After deassertion, the first start SHALL be accepted at the first rising edge where it is high.

Structure
REQ-034 A shared package serial_sub_pkg SHALL hold the FSM state enumeration and the mode encodings SUB_AB=0 and SUB_BA=1.
REQ-035 The 1-bit cell SHALL be a sub-module full_sub_cell (inputs x, y, bi; outputs d, bo), instantiated SLICE times via generate.
REQ-036 The step counter width SHALL be clog2(STEPS+1).
REQ-037 No combinational path SHALL exist from inputs to outputs.

Verification
REQ-038 full_sub_cell exhaustive check: all 8 x/y/bi combinations -> d pattern 0,1,1,0,1,0,0,1 and bo pattern 0,1,1,1,0,0,0,1 (index = {x,y,bi}).
REQ-039 WIDTH=8, SLICE=1: A=0x5A, B=0x3C, Bin=0, mode=0 -> Diff=0x1E, Borr=0, zero=0, done exactly 8 edges after the start edge.
REQ-040 WIDTH=8, SLICE=1: A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Borr=1. Then A=0x10, B=0x0F, Bin=1 -> Diff=0x00, Borr=0, zero=1.
REQ-041 WIDTH=8, SLICE=4, mode=1: A=0x3C, B=0x5A -> Diff=0x1E, Borr=0; done after 2 edges.
REQ-042 Protocol check: start pulsed again mid-RUN with different operands -> ignored, first result unchanged. start asserted during the DONE cycle -> back-to-back operation accepted.
REQ-043 Reset check: rst_n low at step 3 of 8 -> outputs 0 immediately, no done after release. A subsequent 0xFF-0x01 -> Diff=0xFE, Borr=0.
